// File: rtl/cpu_dmem_io.sv
// CPU data-memory responder: scratch RAM plus memory-mapped event FIFO, LFSR and LED register.
// Reads are combinational from ADDR; all state updates on the rising CLK edge.
module cpu_dmem_io #(
    parameter int         RAM_DEPTH  = 192,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
    input  logic       CLK,
    input  logic       RESET_L,
    input  logic [7:0] ADDR,
    input  logic [7:0] WDATA,
    input  logic       MW,
    output logic [7:0] RDATA,
    input  logic       EVT_VALID,
    input  logic [7:0] EVT_CODE,
    output logic       EN_L,
    output logic [7:0] LED,
    output logic       OVF
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int RAM_AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

    localparam logic [7:0] ADDR_FIFO   = 8'hF0;
    localparam logic [7:0] ADDR_STATUS = 8'hF1;
    localparam logic [7:0] ADDR_LFSR   = 8'hF2;
    localparam logic [7:0] ADDR_LED    = 8'hF3;

    logic [7:0]       ram     [RAM_DEPTH];
    logic [7:0]       fifoMem [FIFO_DEPTH];
    logic [PTR_W-1:0] headPtr;
    logic [PTR_W-1:0] tailPtr;
    logic [CNT_W-1:0] fifoCount;
    logic [7:0]       lfsr;

    logic ramHit;
    logic nonEmpty;
    logic fifoFull;
    logic statusWr;
    logic doPop;
    logic doPush;
    logic ovfSet;
    logic ovfClr;

    assign ramHit   = ({24'b0, ADDR} < 32'(RAM_DEPTH));
    assign nonEmpty = (fifoCount != '0);
    assign fifoFull = (fifoCount == CNT_W'(FIFO_DEPTH));
    assign statusWr = MW && (ADDR == ADDR_STATUS);
    assign doPop    = statusWr && WDATA[0] && nonEmpty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign doPush   = EVT_VALID && (!fifoFull || doPop);
    assign ovfSet   = EVT_VALID && !doPush;
    assign ovfClr   = statusWr && WDATA[1];

    // NOTE: storage arrays carry no reset; their contents are only observed
    // through valid pointers/addresses, and a reset branch would block RAM inference.
    always_ff @(posedge CLK) begin
        if (MW && ramHit) begin
            ram[ADDR[RAM_AW-1:0]] <= WDATA;
        end
        if (doPush) begin
            fifoMem[tailPtr] <= EVT_CODE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            headPtr   <= '0;
            tailPtr   <= '0;
            fifoCount <= '0;
            OVF       <= 1'b0;
            EN_L      <= 1'b1;
            LED       <= 8'h00;
            lfsr      <= LFSR_SEED;
        end else begin
            if (doPush) tailPtr <= tailPtr + 1'b1;
            if (doPop)  headPtr <= headPtr + 1'b1;
            case ({doPush, doPop})
                2'b10:   fifoCount <= fifoCount + 1'b1;
                2'b01:   fifoCount <= fifoCount - 1'b1;
                default: fifoCount <= fifoCount;
            endcase

            if (ovfSet)      OVF <= 1'b1;
            else if (ovfClr) OVF <= 1'b0;

            EN_L <= !doPush;

            if (MW && (ADDR == ADDR_LED)) LED <= WDATA;

            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    // NOTE: RDATA gets a default before any branch so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        RDATA = 8'h00;
        if (ramHit) begin
            RDATA = ram[ADDR[RAM_AW-1:0]];
        end else begin
            case (ADDR)
                ADDR_FIFO:   RDATA = nonEmpty ? fifoMem[headPtr] : 8'h00;
                ADDR_STATUS: RDATA = {6'b0, OVF, nonEmpty};
                ADDR_LFSR:   RDATA = lfsr;
                ADDR_LED:    RDATA = LED;
                default:     RDATA = 8'h00;
            endcase
        end
    end

endmodule
